cpu_clk_ctrl: RTL
=================

CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 SHALL have parameter RST_HOLD_CYCLES, default 8: master_clk cycles core_rst_n is held low after reset synchronisation (legal range 1..255).
REQ-002 SHALL have parameter DIV_WIDTH, default 4: width of div_sel and of the internal period counter.
REQ-003 SHALL have port master_clk  in  1  sole clock; all flops on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port div_sel  in  DIV_WIDTH  core enable period minus one (0 = enable every cycle).
REQ-006 SHALL have port halt_req  in  1  level request to stop core enables.
REQ-007 SHALL have port core_rst_n  out  1  core reset, active-low, synchronously released.
REQ-008 SHALL have port core_clk_en  out  1  one-cycle core clock-enable pulse.
REQ-009 SHALL have port halt_ack  out  1  high while core enables are stopped by halt_req.
REQ-010 SHALL have port half_clk  out  1  free-running master_clk/2 square wave.
REQ-011 SHALL have port cycle_count  out  32  number of core_clk_en pulses issued since reset.

Function
REQ-012 SHALL synchronise rst_n release through a 2-flop synchroniser; internal logic leaves reset only on synchronised release.
REQ-013 SHALL implement states RESET_HOLD, RUN, HALTING, HALTED; reset state RESET_HOLD.
REQ-014 SHALL, in RESET_HOLD, count RST_HOLD_CYCLES cycles with core_rst_n=0, then enter RUN and drive core_rst_n=1 from that edge.
REQ-015 SHALL load the period counter with div_sel on RUN entry and on every core_clk_en pulse; otherwise decrement it each cycle in RUN/HALTING.
REQ-016 SHALL assert core_clk_en, decoded from registers only, in any RUN or HALTING cycle where period counter == 0; never in RESET_HOLD or HALTED.
REQ-017 SHALL give pulse period div_sel+1 cycles; first pulse div_sel cycles after the RUN-entry edge; div_sel changes take effect only at the next reload.
REQ-018 SHALL transition RUN -> HALTING when halt_req=1 is sampled in a non-pulse cycle; RUN -> HALTED when sampled in a pulse cycle (that pulse still issues).
REQ-019 SHALL, in HALTING, issue the pending pulse, then enter HALTED; if halt_req=0 is sampled in HALTING, return to RUN without reloading the counter.
REQ-020 SHALL drive halt_ack=1 exactly while in HALTED.
REQ-021 SHALL, in HALTED with halt_req=0 sampled, enter RUN next edge (halt_ack low that edge), reloading the counter from div_sel.
REQ-022 SHALL increment cycle_count by 1 on each core_clk_en cycle, wrapping 0xFFFF_FFFF -> 0.
REQ-023 SHALL toggle half_clk every master_clk edge once synchronised reset is released, independent of state.

Reset
REQ-024 SHALL, on rst_n=0, immediately (asynchronously) force core_rst_n=0, core_clk_en=0, halt_ack=0, half_clk=0, cycle_count=0, state=RESET_HOLD, period counter=0, synchroniser=0.
REQ-025 SHALL treat rst_n assertion in any state, including mid-HALTING, as a full restart; no pulse issues during or after it until REQ-014/017 timing completes.
REQ-026 SHALL ignore halt_req while in RESET_HOLD.

Verification
REQ-027 Reset release, default params, div_sel=0: core_rst_n rises 10 edges after first edge with rst_n=1 (2 sync + 8 hold); core_clk_en high every cycle thereafter; cycle_count=5 after 5 RUN cycles.
REQ-028 div_sel=3 in RUN: core_clk_en high 1 cycle of every 4; first pulse 3 cycles after RUN entry; change div_sel to 1 mid-period -> current period stays 4, next periods 2.
REQ-029 halt_req raised 1 cycle after a pulse, div_sel=3: 2 more cycles in HALTING, pulse issues, halt_ack=1 next edge, no further pulses; drop halt_req -> halt_ack=0 next edge, next pulse 3 cycles later.
REQ-030 halt_req raised in a pulse cycle -> that pulse counted, HALTED next edge; halt_req pulsed high 1 cycle in HALTING -> returns to RUN, pending pulse on original schedule.
REQ-031 Preload cycle_count via forced pulses to 0xFFFF_FFFE: two pulses -> 0xFFFF_FFFF then 0x0000_0000.
REQ-032 rst_n low mid-HALTING for 1 cycle asynchronously -> all outputs reset values with no clock edge; half_clk restarts at 0; REQ-027 timing repeats.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_clk_ctrl
// Description : CPU clock/reset controller. Synchronises the external reset
//               release, holds the core in reset for a fixed number of
//               cycles, then issues a programmable-period clock-enable pulse
//               with a halt/resume handshake and a pulse counter.
// Ports       : master_clk  - sole clock (rising edge)
//               rst_n       - asynchronous active-low reset
//               div_sel     - enable period minus one (0 = every cycle)
//               halt_req    - level request to stop core enables
//               core_rst_n  - core reset, active-low, synchronously released
//               core_clk_en - one-cycle core clock-enable pulse
//               halt_ack    - high while enables are stopped by halt_req
//               half_clk    - free-running master_clk/2 square wave
//               cycle_count - number of core_clk_en pulses since reset
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_clk_ctrl #(
    parameter int RST_HOLD_CYCLES = 8,
    parameter int DIV_WIDTH       = 4
) (
    input  logic                 master_clk,
    input  logic                 rst_n,
    input  logic [DIV_WIDTH-1:0] div_sel,
    input  logic                 halt_req,
    output logic                 core_rst_n,
    output logic                 core_clk_en,
    output logic                 halt_ack,
    output logic                 half_clk,
    output logic [31:0]          cycle_count
);

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        HALTING    = 2'd2,
        HALTED     = 2'd3
    } state_t;

    localparam logic [7:0] c_hold_last = 8'(RST_HOLD_CYCLES - 1);

    logic [1:0]           r_sync;
    state_t               r_state;
    logic [7:0]           r_hold_cnt;
    logic [DIV_WIDTH-1:0] r_period;
    logic                 r_core_rst_n;
    logic                 r_half_clk;
    logic [31:0]          r_cycle_count;

    logic                 w_rel;
    logic                 w_pulse;

    // Everything except the synchroniser itself stays frozen in its reset
    // value until the released reset has passed through both flops.
    assign w_rel   = r_sync[1];
    assign w_pulse = ((r_state == RUN) || (r_state == HALTING)) && (r_period == '0);

    assign core_rst_n  = r_core_rst_n;
    assign core_clk_en = w_pulse;
    assign halt_ack    = (r_state == HALTED);
    assign half_clk    = r_half_clk;
    assign cycle_count = r_cycle_count;

    always_ff @(posedge master_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    always_ff @(posedge master_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RESET_HOLD;
            r_hold_cnt    <= 8'd0;
            r_period      <= '0;
            r_core_rst_n  <= 1'b0;
            r_half_clk    <= 1'b0;
            r_cycle_count <= 32'd0;
        end else if (w_rel) begin
            r_half_clk <= ~r_half_clk;

            if (w_pulse) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end

            // The period counter runs identically in RUN and HALTING, so a
            // cancelled halt resumes on the original pulse schedule.
            if ((r_state == RUN) || (r_state == HALTING)) begin
                if (w_pulse) begin
                    r_period <= div_sel;
                end else begin
                    r_period <= r_period - DIV_WIDTH'(1);
                end
            end

            case (r_state)
                RESET_HOLD: begin
                    if (r_hold_cnt == c_hold_last) begin
                        r_state      <= RUN;
                        r_core_rst_n <= 1'b1;
                        r_period     <= div_sel;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                RUN: begin
                    // A halt sampled in a pulse cycle lets that pulse issue
                    // and stops immediately; otherwise wait for the pending one.
                    if (halt_req) begin
                        r_state <= w_pulse ? HALTED : HALTING;
                    end
                end
                HALTING: begin
                    if (!halt_req) begin
                        r_state <= RUN;
                    end else if (w_pulse) begin
                        r_state <= HALTED;
                    end
                end
                HALTED: begin
                    if (!halt_req) begin
                        r_state  <= RUN;
                        r_period <= div_sel;
                    end
                end
                default: begin
                    r_state <= RESET_HOLD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
